// File: rtl/issue_pkg.sv
// Shared issue-queue definitions: index width helper, per-entry state and wakeup tag match.
package issue_pkg;

    localparam int unsigned IQ_DEPTH_DEF = 32;
    localparam int unsigned TAG_W_DEF    = 7;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned IQ_IDX_W = idx_width(IQ_DEPTH_DEF);

    typedef logic [TAG_W_DEF-1:0] phy_tag_t;

    typedef struct packed {
        logic     valid;
        logic     src1_rdy;
        logic     src2_rdy;
        phy_tag_t src1_tag;
        phy_tag_t src2_tag;
    } iq_entry_t;

    function automatic logic wakeup_match(
        input logic     lane_valid,
        input phy_tag_t lane_tag,
        input phy_tag_t src_tag
    );
        return lane_valid && (lane_tag == src_tag);
    endfunction

endpackage

// File: rtl/wakeup_cam.sv
// Compares one source tag against every wakeup broadcast lane.
module wakeup_cam
    import issue_pkg::*;
#(
    parameter int unsigned WAKEUP_WIDTH = 2
) (
    input  phy_tag_t                    tag,
    input  logic [WAKEUP_WIDTH-1:0]     wakeup_valid,
    input  phy_tag_t [WAKEUP_WIDTH-1:0] wakeup_tag,
    output logic                        hit_c
);

    always_comb begin
        hit_c = 1'b0;
        for (int unsigned l = 0; l < WAKEUP_WIDTH; l++) begin
            hit_c = hit_c | wakeup_match(wakeup_valid[l], wakeup_tag[l], tag);
        end
    end

endmodule

// File: rtl/issue_req_gen.sv
// Issue-queue request generator: tracks entry readiness and drives the select request vector.
// Optional ISSUE_REQ_REGOUT_EN registers requestVector_o and masks the just-granted entry.
module issue_req_gen
    import issue_pkg::*;
#(
    parameter  int unsigned ISSUE_DEPTH    = IQ_DEPTH_DEF,
    parameter  int unsigned PHY_TAG_W      = TAG_W_DEF,
    parameter  int unsigned DISPATCH_WIDTH = 2,
    parameter  int unsigned WAKEUP_WIDTH   = 2,
    localparam int unsigned IDX_W          = idx_width(ISSUE_DEPTH),
    localparam int unsigned OCC_W          = IDX_W + 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [DISPATCH_WIDTH-1:0]                dispValid_i,
    input  logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]     dispEntry_i,
    input  logic [DISPATCH_WIDTH-1:0][PHY_TAG_W-1:0] dispSrc1Tag_i,
    input  logic [DISPATCH_WIDTH-1:0][PHY_TAG_W-1:0] dispSrc2Tag_i,
    input  logic [DISPATCH_WIDTH-1:0]                dispSrc1Rdy_i,
    input  logic [DISPATCH_WIDTH-1:0]                dispSrc2Rdy_i,
    input  logic [WAKEUP_WIDTH-1:0]                  wakeupValid_i,
    input  logic [WAKEUP_WIDTH-1:0][PHY_TAG_W-1:0]   wakeupTag_i,
    input  logic                                     grantValid_i,
    input  logic [IDX_W-1:0]                         grantEntry_i,
    input  logic                                     flush_i,
    output logic [ISSUE_DEPTH-1:0]                   requestVector_o,
    output logic [ISSUE_DEPTH-1:0]                   validVector_o,
    output logic [OCC_W-1:0]                         occupancy_o
);

    iq_entry_t                   ent_q [ISSUE_DEPTH];
    iq_entry_t                   ent_d [ISSUE_DEPTH];
    phy_tag_t [WAKEUP_WIDTH-1:0] wk_tag;
    logic [ISSUE_DEPTH-1:0]      ent_hit1, ent_hit2;
    logic [DISPATCH_WIDTH-1:0]   disp_hit1, disp_hit2;
    logic [ISSUE_DEPTH-1:0]      req_c, valid_c;
    logic [OCC_W-1:0]            occ_d, occ_q;
    logic                        disp_clash_c, grant_idle_c;

    always_comb begin
        for (int unsigned l = 0; l < WAKEUP_WIDTH; l++) begin
            wk_tag[l] = TAG_W_DEF'(wakeupTag_i[l]);
        end
    end

    // One CAM per stored source and per dispatching source (the latter gives the bypass).
    for (genvar e = 0; e < ISSUE_DEPTH; e++) begin : g_ent_cam
        wakeup_cam #(.WAKEUP_WIDTH(WAKEUP_WIDTH)) u_cam1 (
            .tag          (ent_q[e].src1_tag),
            .wakeup_valid (wakeupValid_i),
            .wakeup_tag   (wk_tag),
            .hit_c        (ent_hit1[e])
        );
        wakeup_cam #(.WAKEUP_WIDTH(WAKEUP_WIDTH)) u_cam2 (
            .tag          (ent_q[e].src2_tag),
            .wakeup_valid (wakeupValid_i),
            .wakeup_tag   (wk_tag),
            .hit_c        (ent_hit2[e])
        );
    end

    for (genvar d = 0; d < DISPATCH_WIDTH; d++) begin : g_disp_cam
        wakeup_cam #(.WAKEUP_WIDTH(WAKEUP_WIDTH)) u_cam1 (
            .tag          (TAG_W_DEF'(dispSrc1Tag_i[d])),
            .wakeup_valid (wakeupValid_i),
            .wakeup_tag   (wk_tag),
            .hit_c        (disp_hit1[d])
        );
        wakeup_cam #(.WAKEUP_WIDTH(WAKEUP_WIDTH)) u_cam2 (
            .tag          (TAG_W_DEF'(dispSrc2Tag_i[d])),
            .wakeup_valid (wakeupValid_i),
            .wakeup_tag   (wk_tag),
            .hit_c        (disp_hit2[d])
        );
    end

    // Update priority, lowest to highest: wakeup, grant, dispatch, flush.
    always_comb begin
        for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
            ent_d[e] = ent_q[e];
            if (ent_q[e].valid) begin
                if (ent_hit1[e]) ent_d[e].src1_rdy = 1'b1;
                if (ent_hit2[e]) ent_d[e].src2_rdy = 1'b1;
            end
        end
        if (grantValid_i) begin
            ent_d[grantEntry_i].valid = 1'b0;
        end
        for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
            if (dispValid_i[d]) begin
                ent_d[dispEntry_i[d]].valid    = 1'b1;
                ent_d[dispEntry_i[d]].src1_rdy = dispSrc1Rdy_i[d] | disp_hit1[d];
                ent_d[dispEntry_i[d]].src2_rdy = dispSrc2Rdy_i[d] | disp_hit2[d];
                ent_d[dispEntry_i[d]].src1_tag = TAG_W_DEF'(dispSrc1Tag_i[d]);
                ent_d[dispEntry_i[d]].src2_tag = TAG_W_DEF'(dispSrc2Tag_i[d]);
            end
        end
        if (flush_i) begin
            for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
                ent_d[e].valid    = 1'b0;
                ent_d[e].src1_rdy = 1'b0;
                ent_d[e].src2_rdy = 1'b0;
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
            occ_d = occ_d + OCC_W'(ent_d[e].valid);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
                ent_q[e] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
                ent_q[e] <= ent_d[e];
            end
            occ_q <= occ_d;
        end
    end

    always_comb begin
        for (int unsigned e = 0; e < ISSUE_DEPTH; e++) begin
            valid_c[e] = ent_q[e].valid;
            req_c[e]   = ent_q[e].valid & ent_q[e].src1_rdy & ent_q[e].src2_rdy;
        end
    end

    assign validVector_o = valid_c;
    assign occupancy_o   = occ_q;

`ifdef ISSUE_REQ_REGOUT_EN
    logic [ISSUE_DEPTH-1:0] req_q, grant_mask_c;

    always_comb begin
        grant_mask_c = '0;
        if (grantValid_i) grant_mask_c[grantEntry_i] = 1'b1;
    end

    // Registered copy lags state by a cycle, so drop the entry granted this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q <= '0;
        end else if (flush_i) begin
            req_q <= '0;
        end else begin
            req_q <= req_c & ~grant_mask_c;
        end
    end

    assign requestVector_o = req_q;
`else
    assign requestVector_o = req_c;
`endif

    // Illegal dispatch: occupied entry not freed this cycle, or two lanes on one entry.
    always_comb begin
        disp_clash_c = 1'b0;
        for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
            if (dispValid_i[d]) begin
                if (!flush_i && ent_q[dispEntry_i[d]].valid &&
                    !(grantValid_i && (grantEntry_i == dispEntry_i[d]))) begin
                    disp_clash_c = 1'b1;
                end
                for (int unsigned k = d + 1; k < DISPATCH_WIDTH; k++) begin
                    if (dispValid_i[k] && (dispEntry_i[k] == dispEntry_i[d])) begin
                        disp_clash_c = 1'b1;
                    end
                end
            end
        end
    end

    assign grant_idle_c = grantValid_i && !ent_q[grantEntry_i].valid;

    a_disp_legal : assert property (@(posedge clk) disable iff (!reset) !disp_clash_c);
    a_grant_live : assert property (@(posedge clk) disable iff (!reset) !grant_idle_c);

endmodule
